spindle_starter: RTL and testbench
==================================

SPINDLE_STARTER -- requirements
Module: spindle_starter

Interface
REQ-001 SHALL have parameter CNT_W, default 28, width of the shared phase counter.
REQ-002 SHALL have parameter STAR_CYCLES, default 100_000_000, star-phase duration in clk cycles (2 s @ 50 MHz).
REQ-003 SHALL have parameter DEAD_CYCLES, default 2_500_000, open-transition gap in cycles (50 ms).
REQ-004 SHALL have parameter BRAKE_CYCLES, default 50_000_000, brake-pulse duration in cycles (1 s).
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ena  input  1  advance enable; 0 freezes state and counter.
REQ-008 SHALL have port ctrl_req  input  1  run request from the PLC timer stage, same clock domain.
REQ-009 SHALL have port estop_n  input  1  emergency stop, asynchronous external, low = stop.
REQ-010 SHALL have port overload  input  1  thermal overload relay, asynchronous external, high = trip.
REQ-011 SHALL have port fault_clr  input  1  fault acknowledge, same clock domain, level-sampled.
REQ-012 SHALL have outputs k_main, k_star, k_delta, k_brake, running, fault, each output 1, driving contactors and status.
REQ-013 SHALL have port state_o  output  3  current state encoding, for debug.

Function
REQ-014 SHALL pass estop_n and overload through a two-flop synchronizer before use; ctrl_req and fault_clr SHALL be used directly.
REQ-015 SHALL implement Moore FSM states IDLE, STAR, GAP, DELTA, BRAKE, FAULT; all outputs SHALL decode from the state register only.
REQ-016 Outputs per state: IDLE all 0; STAR k_main=k_star=1; GAP k_main=1; DELTA k_main=k_delta=running=1; BRAKE k_brake=1; FAULT fault=1; unlisted outputs 0.
REQ-017 IDLE->STAR on the edge sampling ctrl_req=1 with no synchronized fault; k_star SHALL assert the following cycle.
REQ-018 Counter SHALL clear on every state entry; STAR, GAP and BRAKE SHALL each last exactly N cycles (exit when counter==N-1). Order: STAR->GAP->DELTA, BRAKE->IDLE.
REQ-019 ctrl_req=0 in STAR, GAP or DELTA SHALL enter BRAKE on the next edge, including on a phase's final cycle. That edge takes priority over the phase transition.
REQ-020 ctrl_req during BRAKE SHALL be ignored; a restart is possible only from IDLE.
REQ-021 Synchronized estop_n=0 or overload=1 SHALL force FAULT from any state on the next edge, regardless of ena, with priority over all other transitions.
REQ-022 FAULT->IDLE only when fault_clr=1, ctrl_req=0, synchronized estop_n=1 and overload=0, all in the same cycle; otherwise FAULT SHALL hold.
REQ-023 k_star and k_delta SHALL never both be 1; k_brake SHALL never be 1 together with k_main.
REQ-024 With ena=0 the FSM and counter SHALL hold, except for REQ-021.
REQ-025 Parameters SHALL be >=1 and <2^CNT_W; out-of-range values SHALL raise an elaboration error.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, synchronizer flops to their safe level, and all outputs 0.
REQ-027 After reset release, the first transition SHALL occur no earlier than the third edge, once synchronizers are valid.

Configuration
REQ-028 With SPINDLE_BRAKE_EN defined, the BRAKE state SHALL be implemented as specified.
REQ-029 Without SPINDLE_BRAKE_EN, the BRAKE state SHALL be absent, k_brake SHALL be tied 0, and every REQ-019 exit SHALL go directly to IDLE.

Structure
REQ-030 SHALL import package spindle_pkg, which holds the state typedef, the 3-bit encodings and the default timing constants.
REQ-031 Synchronization SHALL be a sub-module sync_2ff instantiated twice.

Verification (STAR=10, DEAD=3, BRAKE=5)
REQ-032 ctrl_req=1 from cycle 0 -> k_star high in cycles 1-10, GAP in cycles 11-13, k_delta and running from cycle 14.
REQ-033 ctrl_req dropped in DELTA -> all contactors 0 next cycle, k_brake high for 5 cycles, then IDLE; without the macro -> IDLE next cycle, k_brake 0.
REQ-034 ctrl_req dropped on the 10th STAR cycle -> BRAKE, k_delta never asserts.
REQ-035 overload pulsed for 1 cycle during STAR -> fault=1 by the third edge, contactors 0; fault_clr with ctrl_req=1 ignored; fault_clr with ctrl_req=0 -> IDLE.
REQ-036 ena=0 for 4 cycles mid-STAR -> STAR extends by 4 cycles; estop_n=0 while ena=0 -> FAULT.
REQ-037 rst_n low mid-DELTA -> all outputs 0 without waiting for clk, state_o=IDLE.

Source files
------------

// File: rtl/spindle_pkg.sv
// Shared state encodings, output bundle and default timing for the spindle starter.
package spindle_pkg;

    localparam int DEF_CNT_W        = 28;
    localparam int DEF_STAR_CYCLES  = 100_000_000;
    localparam int DEF_DEAD_CYCLES  = 2_500_000;
    localparam int DEF_BRAKE_CYCLES = 50_000_000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STAR  = 3'd1,
        ST_GAP   = 3'd2,
        ST_DELTA = 3'd3,
        ST_BRAKE = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    typedef struct packed {
        logic k_main;
        logic k_star;
        logic k_delta;
        logic k_brake;
        logic running;
        logic fault;
    } outs_t;

    // Moore decode: contactor and status levels owned by each state.
    function automatic outs_t state_outs(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            ST_STAR: begin
                o.k_main = 1'b1;
                o.k_star = 1'b1;
            end
            ST_GAP:   o.k_main = 1'b1;
            ST_DELTA: begin
                o.k_main  = 1'b1;
                o.k_delta = 1'b1;
                o.running = 1'b1;
            end
            ST_BRAKE: o.k_brake = 1'b1;
            ST_FAULT: o.fault   = 1'b1;
            default:  o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level; RST_VAL is the level held in reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spindle_starter.sv
// Star-delta spindle contactor sequencer with open transition, fault lockout and optional
// brake phase (SPINDLE_BRAKE_EN); outputs are registered copies of the state decode.
module spindle_starter
    import spindle_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int STAR_CYCLES  = DEF_STAR_CYCLES,
    parameter int DEAD_CYCLES  = DEF_DEAD_CYCLES,
    parameter int BRAKE_CYCLES = DEF_BRAKE_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       ctrl_req,
    input  logic       estop_n,
    input  logic       overload,
    input  logic       fault_clr,
    output logic       k_main,
    output logic       k_star,
    output logic       k_delta,
    output logic       k_brake,
    output logic       running,
    output logic       fault,
    output logic [2:0] state_o
);

    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
        $error("spindle_starter: CNT_W must be within 1..31");
    end
    if (STAR_CYCLES < 1 || longint'(STAR_CYCLES) >= (longint'(1) << CNT_W) ||
        DEAD_CYCLES < 1 || longint'(DEAD_CYCLES) >= (longint'(1) << CNT_W) ||
        BRAKE_CYCLES < 1 || longint'(BRAKE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_cycles
        $error("spindle_starter: phase durations must be >= 1 and < 2**CNT_W");
    end

`ifdef SPINDLE_BRAKE_EN
    localparam logic   BRAKE_EN = 1'b1;
    localparam state_t STOP_ST  = ST_BRAKE;
    localparam logic [CNT_W-1:0] BRAKE_LAST = CNT_W'(BRAKE_CYCLES - 1);
`else
    localparam logic   BRAKE_EN = 1'b0;
    localparam state_t STOP_ST  = ST_IDLE;
`endif
    localparam logic [CNT_W-1:0] STAR_LAST = CNT_W'(STAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    state_t           state;
    state_t           nxt;
    outs_t            outs_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       rdy_sh;
    logic             sync_ok;
    logic             estop_s;
    logic             overload_s;
    logic             fault_in;
    logic             timed;

    // Synchronizers reset to the stopped/tripped level; rdy_sh masks them until they hold real samples.
    sync_2ff #(.RST_VAL(1'b0)) u_sync_estop (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (estop_n),
        .q     (estop_s)
    );

    sync_2ff #(.RST_VAL(1'b1)) u_sync_overload (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (overload),
        .q     (overload_s)
    );

    assign sync_ok  = rdy_sh[1];
    assign fault_in = !estop_s || overload_s;
    assign timed    = (state == ST_STAR) || (state == ST_GAP) || (state == ST_BRAKE);

    always_comb begin
        nxt = state;
        if (sync_ok) begin
            if (fault_in) begin
                nxt = ST_FAULT;
            end else if (ena) begin
                case (state)
                    ST_IDLE:  if (ctrl_req) nxt = ST_STAR;
                    ST_STAR: begin
                        if (!ctrl_req)              nxt = STOP_ST;
                        else if (cnt == STAR_LAST)  nxt = ST_GAP;
                    end
                    ST_GAP: begin
                        if (!ctrl_req)              nxt = STOP_ST;
                        else if (cnt == DEAD_LAST)  nxt = ST_DELTA;
                    end
                    ST_DELTA: if (!ctrl_req) nxt = STOP_ST;
`ifdef SPINDLE_BRAKE_EN
                    ST_BRAKE: if (cnt == BRAKE_LAST) nxt = ST_IDLE;
`endif
                    ST_FAULT: if (fault_clr && !ctrl_req) nxt = ST_IDLE;
                    default:  nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            outs_q <= '0;
            cnt    <= '0;
            rdy_sh <= 2'b00;
        end else begin
            rdy_sh <= {rdy_sh[0], 1'b1};
            state  <= nxt;
            outs_q <= state_outs(nxt);
            if (nxt != state)
                cnt <= '0;
            else if (ena && sync_ok && timed)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign k_main  = outs_q.k_main;
    assign k_star  = outs_q.k_star;
    assign k_delta = outs_q.k_delta;
    assign k_brake = BRAKE_EN & outs_q.k_brake;
    assign running = outs_q.running;
    assign fault   = outs_q.fault;
    assign state_o = state;

endmodule

// File: tb/tb_spindle_starter.sv
// Scoreboarded directed bench for spindle_starter with STAR=10, DEAD=3, BRAKE=5.
module tb_spindle_starter;
    import spindle_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, ena, ctrl_req, estop_n, overload, fault_clr;
    logic       k_main, k_star, k_delta, k_brake, running, fault;
    logic [2:0] state_o;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic [2:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    spindle_starter #(
        .CNT_W        (8),
        .STAR_CYCLES  (10),
        .DEAD_CYCLES  (3),
        .BRAKE_CYCLES (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .ctrl_req  (ctrl_req),
        .estop_n   (estop_n),
        .overload  (overload),
        .fault_clr (fault_clr),
        .k_main    (k_main),
        .k_star    (k_star),
        .k_delta   (k_delta),
        .k_brake   (k_brake),
        .running   (running),
        .fault     (fault),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    // Edge index since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Required levels {k_main, k_star, k_delta, k_brake, running, fault} per state.
    function automatic logic [5:0] exp_outs(input logic [2:0] s);
        case (s)
            ST_STAR:  return 6'b110000;
            ST_GAP:   return 6'b100000;
            ST_DELTA: return 6'b101010;
            ST_BRAKE: return 6'b000100;
            ST_FAULT: return 6'b000001;
            default:  return 6'b000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got state/outs %b_%b, required %b_%b",
                     name, got[8:6], got[5:0], want[8:6], want[5:0]);
        end
    endtask

    task automatic expect_range(input int c0, input int c1, input logic [2:0] s);
        for (int c = c0; c <= c1; c++) sb.push_back('{cyc: c, st: s});
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if ((k_star && k_delta) || (k_brake && k_main)) begin
                n_bad++;
                $display("FAIL interlock cyc %0d: got star=%b delta=%b main=%b brake=%b, required no overlap",
                         cyc, k_star, k_delta, k_main, k_brake);
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.cyc < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missed cyc %0d: got no sample, required state %0d", mon_e.cyc, mon_e.st);
                end else begin
                    check($sformatf("cyc%0d", cyc),
                          {state_o, k_main, k_star, k_delta, k_brake, running, fault},
                          {mon_e.st, exp_outs(mon_e.st)});
                end
            end
        end
    end

    initial begin
        #5000;
        n_bad++;
        $display("FAIL watchdog: got no completion by t=5000, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        ctrl_req  = 1'b0;
        estop_n   = 1'b1;
        overload  = 1'b0;
        fault_clr = 1'b0;
        #2;
        check("reset", {state_o, k_main, k_star, k_delta, k_brake, running, fault}, {ST_IDLE, 6'b0});

        // Release with a run request already pending: no move before the third edge.
        #10;
        rst_n    = 1'b1;
        ctrl_req = 1'b1;
        expect_range(1, 2, ST_IDLE);
        expect_range(3, 12, ST_STAR);
        expect_range(13, 15, ST_GAP);
        expect_range(16, 20, ST_DELTA);

        step_to(20);
        ctrl_req = 1'b0;
`ifdef SPINDLE_BRAKE_EN
        expect_range(21, 25, ST_BRAKE);
        expect_range(26, 30, ST_IDLE);
        step_to(22);
        ctrl_req = 1'b1;
        step_to(24);
        ctrl_req = 1'b0;
`else
        expect_range(21, 30, ST_IDLE);
`endif

        // Stop request on the final star cycle wins over the star-to-gap step.
        step_to(30);
        ctrl_req = 1'b1;
        expect_range(31, 40, ST_STAR);
`ifdef SPINDLE_BRAKE_EN
        expect_range(41, 45, ST_BRAKE);
        expect_range(46, 50, ST_IDLE);
`else
        expect_range(41, 50, ST_IDLE);
`endif
        step_to(40);
        ctrl_req = 1'b0;

        // One-cycle overload pulse, then acknowledge with and without a run request.
        step_to(50);
        ctrl_req = 1'b1;
        expect_range(51, 55, ST_STAR);
        expect_range(56, 60, ST_FAULT);
        expect_range(61, 64, ST_IDLE);
        step_to(53);
        overload = 1'b1;
        step_to(54);
        overload = 1'b0;
        step_to(58);
        fault_clr = 1'b1;
        step_to(60);
        ctrl_req = 1'b0;
        step_to(61);
        fault_clr = 1'b0;

        // Four frozen cycles stretch the star phase; estop still trips while frozen.
        step_to(64);
        ctrl_req = 1'b1;
        expect_range(65, 78, ST_STAR);
        expect_range(79, 81, ST_GAP);
        expect_range(82, 86, ST_DELTA);
        expect_range(87, 92, ST_FAULT);
        expect_range(93, 95, ST_IDLE);
        step_to(67);
        ena = 1'b0;
        step_to(71);
        ena = 1'b1;
        step_to(84);
        ena     = 1'b0;
        estop_n = 1'b0;
        step_to(90);
        estop_n   = 1'b1;
        ena       = 1'b1;
        ctrl_req  = 1'b0;
        fault_clr = 1'b1;
        step_to(93);
        fault_clr = 1'b0;

        // Asynchronous reset while running in delta.
        step_to(95);
        ctrl_req = 1'b1;
        expect_range(96, 105, ST_STAR);
        expect_range(106, 108, ST_GAP);
        expect_range(109, 111, ST_DELTA);
        step_to(112);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {state_o, k_main, k_star, k_delta, k_brake, running, fault}, {ST_IDLE, 6'b0});
        ctrl_req = 1'b0;
        #20;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
